// File: rtl/unified_mem_ctrl_pkg.sv
// mem_pkg: shared state encoding, counter width and derived-geometry helpers for unified_mem_ctrl
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int CNT_W = 4;
  function automatic int bytesOf(input int dataWidth);
    return dataWidth / 8;
  endfunction
  function automatic int addrLsbOf(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction
  function automatic int idxWOf(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/unified_mem_ctrl_if.sv
// unified_mem_ctrl_if: request/response bus between the CPU control FSM and the memory controller
interface unified_mem_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic Req;
  logic IorD;
  logic MemWrite;
  logic [DATA_WIDTH/8-1:0] ByteEn;
  logic [ADDRESS_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] MemData;
  logic Ready;
  logic Busy;
  logic Err;
  modport master (output Req, IorD, MemWrite, ByteEn, Address, WriteData, input MemData, Ready, Busy, Err);
  modport slave (input Req, IorD, MemWrite, ByteEn, Address, WriteData, output MemData, Ready, Busy, Err);
endinterface

// File: rtl/unified_mem_ctrl_mem_array.sv
// mem_array: synchronous single-port byte-writable RAM with a registered read port
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic en,
  input  logic we,
  input  logic [DATA_WIDTH/8-1:0] byteEn,
  input  logic [IDX_W-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // byte-masked write; contents are deliberately never reset
  always_ff @(posedge Clk) begin
    if (en && we)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (byteEn[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  // read register only moves on a read, so it holds the last read word
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rdata <= '0;
    else if (en && !we) rdata <= mem[idx];
  end
endmodule

// File: rtl/unified_mem_ctrl.sv
// unified_mem_ctrl: handshaked wait-state controller for the shared instruction/data RAM (optional MEM_BOUNDS_CHECK_EN)
module unified_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 2,
  parameter int TEXT_WORDS = 256
) (
  input logic Clk,
  input logic Rst_n,
  unified_mem_ctrl_if.slave bus
);
  localparam int BYTES = bytesOf(DATA_WIDTH);
  localparam int ADDR_LSB = addrLsbOf(DATA_WIDTH);
  localparam int IDX_W = idxWOf(DEPTH);
  localparam logic [CNT_W-1:0] LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  state_t state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [IDX_W-1:0] idxQ, accIdx;
  logic iordQ, wrQ, oorQ, accIord, accWr, accOor;
  logic [BYTES-1:0] beQ, accBe;
  logic [DATA_WIDTH-1:0] wdataQ, accWdata, rdata;
  logic liveOor, acc, instrWr, we, errQ, oorRdQ;
  logic addrUnused;

  assign addrUnused = ^bus.Address;
`ifdef MEM_BOUNDS_CHECK_EN
  assign liveOor = (bus.Address >> (ADDR_LSB + IDX_W)) != '0;
`else
  assign liveOor = 1'b0;
`endif

  // in IDLE the access (WAIT_STATES=0) uses the live request, otherwise the latched copy
  assign accIdx = (state == IDLE) ? bus.Address[ADDR_LSB +: IDX_W] : idxQ;
  assign accIord = (state == IDLE) ? bus.IorD : iordQ;
  assign accWr = (state == IDLE) ? bus.MemWrite : wrQ;
  assign accBe = (state == IDLE) ? bus.ByteEn : beQ;
  assign accWdata = (state == IDLE) ? bus.WriteData : wdataQ;
  assign accOor = (state == IDLE) ? liveOor : oorQ;
  assign acc = (state == IDLE) ? (bus.Req && WAIT_STATES == 0) : (state == WAIT && cnt == '0);
  assign instrWr = !accIord && accWr;
  assign we = accWr && !instrWr && !accOor;

  assign bus.Ready = state == DONE;
  assign bus.Busy = state != IDLE;
  assign bus.Err = bus.Ready && errQ;
  assign bus.MemData = oorRdQ ? '0 : rdata;

  // state, wait counter and request latches
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idxQ <= '0;
      iordQ <= 1'b0;
      wrQ <= 1'b0;
      beQ <= '0;
      wdataQ <= '0;
      oorQ <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      if (state == IDLE && bus.Req) begin
        idxQ <= bus.Address[ADDR_LSB +: IDX_W];
        iordQ <= bus.IorD;
        wrQ <= bus.MemWrite;
        beQ <= bus.ByteEn;
        wdataQ <= bus.WriteData;
        oorQ <= liveOor;
      end
    end
  end

  // next state: count down the wait states, then a single DONE cycle
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    unique case (state)
      IDLE: if (bus.Req) begin
        stateNext = (WAIT_STATES == 0) ? DONE : WAIT;
        cntNext = LOAD;
      end
      WAIT: if (cnt == '0) stateNext = DONE;
            else cntNext = cnt - 1'b1;
      default: stateNext = IDLE;
    endcase
  end

  // error and out-of-range-read flags captured at the access edge
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      errQ <= 1'b0;
      oorRdQ <= 1'b0;
    end else if (acc) begin
      errQ <= instrWr || accOor;
      if (!we) oorRdQ <= accOor;
    end
  end

  mem_array #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) uArray (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .en(acc),
    .we(we),
    .byteEn(accBe),
    .idx(accIdx),
    .wdata(accWdata),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb_unified_mem_ctrl: directed table-driven bench for unified_mem_ctrl (WAIT_STATES=2 and 0 instances)
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic sel = 1'b0;
  logic req = 1'b0, iord = 1'b0, wr = 1'b0;
  logic [3:0] be = '0;
  logic [31:0] addr = '0, wdata = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) busA ();
  unified_mem_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) busB ();

  assign busA.Req = req && !sel;
  assign busB.Req = req && sel;
  assign busA.IorD = iord;
  assign busB.IorD = iord;
  assign busA.MemWrite = wr;
  assign busB.MemWrite = wr;
  assign busA.ByteEn = be;
  assign busB.ByteEn = be;
  assign busA.Address = addr;
  assign busB.Address = addr;
  assign busA.WriteData = wdata;
  assign busB.WriteData = wdata;

  wire rdy = sel ? busB.Ready : busA.Ready;
  wire busy = sel ? busB.Busy : busA.Busy;
  wire err = sel ? busB.Err : busA.Err;
  wire [31:0] md = sel ? busB.MemData : busA.MemData;

  unified_mem_ctrl #(.WAIT_STATES(2)) dutA (.Clk(clk), .Rst_n(rstN), .bus(busA));
  unified_mem_ctrl #(.WAIT_STATES(0)) dutB (.Clk(clk), .Rst_n(rstN), .bus(busB));

  typedef struct {
    logic iord;
    logic wr;
    logic [3:0] be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expMd;
    logic expErr;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // issue one request at the next edge; returns data/err seen while Ready and edges from request edge to Ready
  task automatic access(input logic i, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] mdOut, output logic errOut, output int lat);
    iord = i; wr = w; be = b; addr = a; wdata = d; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    iord = 1'($urandom); wr = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
    lat = 0;
    while (!rdy && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    mdOut = md;
    errOut = err;
    @(posedge clk); #1;
    chk("ready_single_pulse", {31'b0, rdy}, 32'd0);
    chk("busy_back_idle", {31'b0, busy}, 32'd0);
  endtask

  logic [31:0] gotMd;
  logic gotErr;
  int lat, nRdy, nBusy;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 4'hF, 32'h400,  32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'h0, 32'h400,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'h5, 32'h400,  32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h400,  32'h0,        32'hDE22BE44, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'hF, 32'h10,   32'hCAFEF00D, 32'hDE22BE44, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'hF, 32'h10,   32'h12345678, 32'hCAFEF00D, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'h10,   32'h0,        32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 4'hF, 32'h0,    32'hA5A5A5A5, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'h0, 32'h0,    32'hFFFFFFFF, 32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'h0, 32'h3,    32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'hF, 32'h8,    32'h0BADC0DE, 32'hA5A5A5A5, 1'b0};
`ifdef MEM_BOUNDS_CHECK_EN
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h1000, 32'h0,        32'h00000000, 1'b1};
`else
    vecs[11] = '{1'b1, 1'b0, 4'h0, 32'h1000, 32'h0,        32'hA5A5A5A5, 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, busA.Ready}, 32'd0);
    chk("reset_busy", {31'b0, busA.Busy}, 32'd0);
    chk("reset_err", {31'b0, busA.Err}, 32'd0);
    chk("reset_memdata", busA.MemData, 32'd0);
    rstN = 1'b1;

    for (int k = 0; k < 12; k++) begin
      access(vecs[k].iord, vecs[k].wr, vecs[k].be, vecs[k].addr, vecs[k].wdata, gotMd, gotErr, lat);
      chk($sformatf("vec%0d_latency", k), lat, 32'd2);
      chk($sformatf("vec%0d_memdata", k), gotMd, vecs[k].expMd);
      chk($sformatf("vec%0d_err", k), {31'b0, gotErr}, {31'b0, vecs[k].expErr});
    end

    // Req held high: one access per 4 cycles, Busy in WAIT and DONE
    iord = 1'b1; wr = 1'b0; be = 4'h0; addr = 32'h400; req = 1'b1;
    nRdy = 0; nBusy = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      nRdy += int'(rdy);
      nBusy += int'(busy);
    end
    req = 1'b0;
    chk("held_req_ready_count", nRdy, 32'd4);
    chk("held_req_busy_count", nBusy, 32'd12);
    chk("held_req_memdata", md, 32'hDE22BE44);
    chk("held_req_idle", {31'b0, busy}, 32'd0);

    // reset during WAIT of a write must discard it
    iord = 1'b1; wr = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'h55AA55AA; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    chk("midop_busy_before", {31'b0, busy}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    chk("midop_busy", {31'b0, busA.Busy}, 32'd0);
    chk("midop_ready", {31'b0, busA.Ready}, 32'd0);
    chk("midop_err", {31'b0, busA.Err}, 32'd0);
    chk("midop_memdata", busA.MemData, 32'd0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    access(1'b1, 1'b0, 4'h0, 32'h8, 32'h0, gotMd, gotErr, lat);
    chk("midop_read_old", gotMd, 32'h0BADC0DE);
    chk("midop_read_err", {31'b0, gotErr}, 32'd0);

    // zero-wait-state instance
    sel = 1'b1;
    access(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, gotMd, gotErr, lat);
    chk("ws0_write_latency", lat, 32'd0);
    chk("ws0_write_memdata", gotMd, 32'd0);
    access(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, gotMd, gotErr, lat);
    chk("ws0_read_latency", lat, 32'd0);
    chk("ws0_read_memdata", gotMd, 32'h12345678);
    access(1'b0, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, gotMd, gotErr, lat);
    chk("ws0_instr_write_err", {31'b0, gotErr}, 32'd1);
    chk("ws0_instr_write_data", gotMd, 32'h12345678);
    iord = 1'b1; wr = 1'b0; be = 4'h0; addr = 32'h20; req = 1'b1;
    nRdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      nRdy += int'(rdy);
    end
    req = 1'b0;
    chk("ws0_held_req_ready_count", nRdy, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
